// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel, W-bit registered multiplexer with valid/ready on
// every input and on the output. Channel selection is either round-robin
// (starting from ptr_q) or an explicit channel index on sel.
module rr_mux_reg #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load_en;
    logic            gnt_any;
    logic [SELW-1:0] gnt_idx;
    logic [N-1:0]    grant;

    // The output register may take a new word when empty or being drained.
    assign load_en = !out_valid_q || out_ready;

    // Arbitration: manual mode only ever grants sel; round-robin grants the
    // first valid channel at or after ptr_q, wrapping modulo N.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!gnt_any && in_valid[(int'(ptr_q) + k) % N]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'((int'(ptr_q) + k) % N);
                end
            end
        end
    end

    // One-hot grant vector; ready is the grant gated by load enable.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = gnt_any && (gnt_idx == SELW'(i));
        end
    end

    assign in_ready = load_en ? grant : '0;

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                for (int i = 0; i < N; i++) begin
                    if (grant[i]) begin
                        out_data_d = in_data[i*W +: W];
                    end
                end
                out_ch_d = gnt_idx;
                // Manual grants leave the pointer alone so round-robin resumes
                // where it left off.
                if (!mode) begin
                    ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);
                end
            end
        end
    end

    // State registers; asynchronous reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Testbench for rr_mux_reg: directed scenarios on N=4 and N=3 instances plus
// a randomized run against a behavioural reference model.
module tb_rr_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // N=4, W=8 instance
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    // N=3, W=8 instance
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_valid;
    logic        b_out_ready;

    int total = 0;
    int bad   = 0;

    rr_mux_reg #(.W(8), .N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_mux_reg #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .sel(b_sel),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    // Reference choice of channel: -1 when nothing may be granted.
    function automatic int ref_pick(input bit md, input int s, input logic [3:0] v,
                                    input int p, input int n);
        if (md) begin
            if (s < n && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    // Synchronous-to-bench reset; leaves time at posedge+1.
    task automatic do_reset();
        in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0; in_data = '0;
        b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b0; b_in_data = '0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 4'b0001; in_data = 32'h0000_003C; out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            bad++; $display("FAIL reset_preload: valid=%b data=%h want 1/3c", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0; in_valid = '0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0) begin
            bad++; $display("FAIL reset_async: valid=%b data=%h ch=%0d rdy=%b want 0/00/0/0000",
                            out_valid, out_data, out_ch, in_ready);
        end
        #3;
        rst_n = 1'b1;
        in_valid = 4'b1111; in_data = 32'h44_33_22_11; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
            bad++; $display("FAIL reset_first_grant: valid=%b ch=%0d data=%h want 1/0/11",
                            out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid = 4'b1111; in_data = {8'h33, 8'h22, 8'h11, 8'h00}; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'(8'h11 * (k % 4))) begin
                bad++; $display("FAIL rr_seq[%0d]: valid=%b ch=%0d data=%h want 1/%0d/%h",
                                k, out_valid, out_ch, out_data, k % 4, 8'(8'h11 * (k % 4)));
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 4'b0100; in_data = 32'h00_A5_00_00; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++; $display("FAIL single_ready: got %b want 0100", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            bad++; $display("FAIL single_out: valid=%b data=%h ch=%0d want 1/a5/2",
                            out_valid, out_data, out_ch);
        end
        in_valid = 4'b0000;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            bad++; $display("FAIL single_drain: valid=%b data=%h ch=%0d want 0/a5/2",
                            out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 4'b0001; in_data = 32'h77_66_55_5A; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready);
            end
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd0) begin
                bad++; $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d want 1/5a/0",
                                k, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin
            bad++; $display("FAIL bp_release_ready: got %b want 0010", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h55) begin
            bad++; $display("FAIL bp_release_load: valid=%b ch=%0d data=%h want 1/1/55",
                            out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_manual();
        do_reset();
        mode = 1'b1; sel = 2'd1; in_valid = 4'b1010; in_data = 32'h63_00_61_00; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (in_ready !== 4'b0010) begin
                bad++; $display("FAIL man_ready1[%0d]: got %b want 0010", k, in_ready);
            end
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h61) begin
                bad++; $display("FAIL man_out1[%0d]: valid=%b ch=%0d data=%h want 1/1/61",
                                k, out_valid, out_ch, out_data);
            end
        end
        sel = 2'd3;
        #1;
        total++;
        if (in_ready !== 4'b1000) begin
            bad++; $display("FAIL man_ready3: got %b want 1000", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h63) begin
            bad++; $display("FAIL man_out3: valid=%b ch=%0d data=%h want 1/3/63",
                            out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_n3_out_of_range();
        do_reset();
        b_mode = 1'b1; b_sel = 2'd0; b_in_valid = 3'b111; b_in_data = 24'h30_20_10;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (b_out_valid !== 1'b1 || b_out_ch !== 2'd0 || b_out_data !== 8'h10) begin
            bad++; $display("FAIL n3_load: valid=%b ch=%0d data=%h want 1/0/10",
                            b_out_valid, b_out_ch, b_out_data);
        end
        b_sel = 2'd3;
        #1;
        total++;
        if (b_in_ready !== 3'b000) begin
            bad++; $display("FAIL n3_sel3_ready: got %b want 000", b_in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (b_out_valid !== 1'b0) begin
            bad++; $display("FAIL n3_sel3_valid: got %b want 0", b_out_valid);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 1'b0; in_valid = 4'b0010; in_data = 32'hD3_D2_D1_D0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_ch !== 2'd1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL ms_rr1: ch=%0d valid=%b want 1/1", out_ch, out_valid);
        end
        mode = 1'b1; sel = 2'd3; in_valid = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_ch !== 2'd3 || out_data !== 8'hD3) begin
                bad++; $display("FAIL ms_man[%0d]: ch=%0d data=%h want 3/d3", k, out_ch, out_data);
            end
        end
        mode = 1'b0; in_valid = 4'b1111;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++; $display("FAIL ms_resume_ready: got %b want 0100", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_ch !== 2'd2 || out_data !== 8'hD2) begin
            bad++; $display("FAIL ms_resume: ch=%0d data=%h want 2/d2", out_ch, out_data);
        end
    endtask

    task automatic test_random();
        bit         m_v;
        logic [7:0] m_d;
        int         m_c, m_p, g;
        bit         le;
        logic [3:0] hold_v;
        logic [3:0] exp_rdy;
        do_reset();
        m_v = 0; m_d = 8'h00; m_c = 0; m_p = 0; hold_v = '0;
        for (int c = 0; c < 500; c++) begin
            if (($urandom % 12) == 0) mode = ~mode;
            sel       = 2'($urandom % 4);
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < 4; i++) begin
                if (!hold_v[i]) begin
                    in_valid[i]       = 1'($urandom % 2);
                    in_data[i*8 +: 8] = 8'($urandom);
                end
            end
            #1;
            le = !m_v || out_ready;
            g  = ref_pick(mode, int'(sel), in_valid, m_p, 4);
            exp_rdy = (le && g >= 0) ? (4'b0001 << g) : 4'b0000;
            total++;
            if (in_ready !== exp_rdy) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, exp_rdy);
            end
            @(posedge clk); #1;
            if (le) begin
                if (g >= 0) begin
                    m_v = 1; m_d = in_data[g*8 +: 8]; m_c = g;
                    if (!mode) m_p = (g + 1) % 4;
                end else begin
                    m_v = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                hold_v[i] = in_valid[i] && !(le && g == i);
            end
            total++;
            if (out_valid !== m_v || out_data !== m_d || out_ch !== 2'(m_c)) begin
                bad++; $display("FAIL rnd_out[%0d]: valid=%b data=%h ch=%0d want %b/%h/%0d",
                                c, out_valid, out_data, out_ch, m_v, m_d, m_c);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_manual();
        test_n3_out_of_range();
        test_mode_switch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the team's single-bit 2:1 mux. It selects one input per cycle, either by round-robin arbitration or by an explicit select, the way the 2:1 mux uses its `S`. The selected word is registered on the output. It sits between several producer blocks and a single consumer, and sustains one word per cycle without losing data under backpressure.

## Interface
Parameters:
- `W`, 8, data width in bits (≥1)
- `N`, 4, number of input channels (≥2)
- `SELW`, derived = max(1, ceil(log2(N))), select/channel-index width; not to be overridden

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_data`  in  N*W  channel i occupies bits [i*W +: W]
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready (combinational)
- `mode`  in  1  0 = round-robin, 1 = manual select
- `sel`  in  SELW  channel index used when `mode`=1
- `out_data`  out  W  registered output word
- `out_ch`  out  SELW  index of the channel that supplied `out_data`
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  consumer accepts the word

## Operation
- **Load enable.** `load_en = !out_valid || out_ready`.
- **Round-robin grant (`mode`=0).** Scan channels `ptr, ptr+1, …` modulo N and grant the first channel with `in_valid` high.
- **Manual grant (`mode`=1).**
  - Grant channel `sel` if `sel < N` and `in_valid[sel]` is high.
  - Otherwise there is no grant.
  - Other channels are never granted in this mode.
- **Ready.**
  - `in_ready[i] = load_en && grant[i]`.
  - At most one bit of `in_ready` is high.
  - A grant is only issued to a channel whose `in_valid` is high.
- **Transfer on input i.** A transfer happens when `in_valid[i] && in_ready[i]`. On that clock edge:
  - `out_data <= in_data[i]`
  - `out_ch <= i`
  - `out_valid <= 1`
  - if `mode`=0: `ptr <= (i+1) mod N`
  - if `mode`=1: `ptr` is unchanged
- **Load enable with no grant.** `out_valid <= 0`. `out_data` and `out_ch` hold their previous values.
- **Backpressure.** When `!load_en`, the output register holds all of `out_data`, `out_ch` and `out_valid`.
- **Mode and select changes.** A change to `mode` or `sel` takes effect at the next arbitration. A word already in the output register is never dropped or altered.
- **Word arithmetic.** Words pass through unmodified; there is no width conversion.
- **Reset values.**
  - `out_valid`=0
  - `out_data`=0
  - `out_ch`=0
  - `ptr`=0
  - `in_ready` is therefore driven by the all-zero/empty state.

## Timing
- **Latency.** A word accepted at edge k appears on `out_data`/`out_valid` immediately after edge k (1-cycle latency).
- **Throughput.** One word per cycle while `out_ready`=1 and some eligible channel is valid.
- **Simultaneous drain and load.** With `out_valid`=1 and `out_ready`=1 at the same edge, the old word is consumed and a new word is loaded in the same edge, with no bubble.
- **Fairness.** In round-robin mode with all channels valid, grants follow the order `0,1,…,N-1,0,…`. A continuously valid channel waits at most N-1 grants.
- **Pointer wrap.** A grant to N-1 sets `ptr` to 0.
- **Asynchronous reset.** `rst_n` low forces all reset values immediately, without waiting for a clock edge, even mid-transfer. The word held in the output register is discarded. The first edge after release with `rst_n` high performs normal arbitration from `ptr`=0.
- **Input stability.** `in_data` must be stable while `in_valid` is high and not yet accepted. `in_valid` must not drop before acceptance.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-cycle with `out_valid`=1 and `out_data`=0x3C. Required: `out_valid`=0, `out_data`=0, `out_ch`=0 and `in_ready`=0 before the next edge. After release with all inputs valid: first grant is ch0.
2. **Round-robin.** N=4, W=8, `mode`=0, all `in_valid`=1, `in_data` = {0x33,0x22,0x11,0x00}, `out_ready`=1. Required: `out_ch` sequence 0,1,2,3,0 on consecutive cycles, `out_data` 0x00,0x11,0x22,0x33,0x00, `out_valid` continuously 1.
3. **Single channel.** Only ch2 valid with 0xA5. Required: `in_ready`=4'b0100 in that cycle; next cycle `out_data`=0xA5, `out_ch`=2. Then drop `in_valid[2]` with `out_ready`=1. Required: `out_valid`=0 next cycle.
4. **Backpressure.** `out_valid`=1, `out_data`=0x5A, `out_ready`=0 for 3 cycles with all inputs valid. Required: `out_data`=0x5A held, `in_ready`=0 all 3 cycles. Raise `out_ready`. Required: a new word is loaded at the same edge.
5. **Manual select.** `mode`=1, `sel`=1, ch1 and ch3 valid. Required: only ch1 granted, every cycle. Switch to `sel`=3. Required: ch3 granted from the next arbitration. Also N=3 with `sel`=3. Required: `in_ready`=0 and `out_valid` drops.
6. **Mode switch pointer.** In round-robin, grant ch1. Switch to `mode`=1 for 2 cycles granting ch3, then return to `mode`=0 with all valid. Required: next grant is ch2, since `ptr` was not updated in manual mode.
